// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sequencer: channel-number width, default
// sample width and the ADC-channel-to-sequencer-index helper.
package adc_pkg;

  localparam int unsigned ADC_CH_W   = 5;
  localparam int unsigned DATA_W_DEF = 12;
  // One extra bit so channels below the base wrap to an out-of-range index.
  localparam int unsigned IDX_CALC_W = ADC_CH_W + 1;

  // Map an ADC channel number to a sequencer index (out of range if below base).
  function automatic logic [IDX_CALC_W-1:0] ch_to_idx(input logic [ADC_CH_W-1:0] ch,
                                                      input int unsigned        base);
    return {1'b0, ch} - IDX_CALC_W'(base);
  endfunction

endpackage

// File: rtl/adc_channel_avg.sv
// Per-channel accumulator/decimator.
//  clk, rst_n      clock, async active-low reset
//  en              channel enabled; acc/cnt held at 0 while low
//  sample_valid    a response for this channel is present this cycle
//  sample_data     response sample
//  done_c          this sample completes an average (combinational)
//  result_c        averaged (optionally MSB-flipped) result (combinational)
module adc_channel_avg #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned AVG_LOG2   = 4,
  parameter int unsigned SIGNED_OUT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              done_c,
  output logic [DATA_W-1:0] result_c
);

  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((2 ** AVG_LOG2) - 1);
  // Flipping the MSB converts offset binary to two's complement.
  localparam logic [DATA_W-1:0] MSB_FLIP =
    (SIGNED_OUT != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

  logic [ACC_W-1:0] acc_q, acc_d, sum_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accumulate, and complete on the last sample of the window.
  always_comb begin
    sum_c    = acc_q + ACC_W'(sample_data);
    done_c   = en & sample_valid & (cnt_q == CNT_LAST);
    result_c = DATA_W'(sum_c >> AVG_LOG2) ^ MSB_FLIP;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (!en) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sample_valid) begin
      if (done_c) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum_c;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_sequencer.sv
// Round-robin command sequencer and per-channel averager for the on-chip ADC.
//  clk, rst_n               ADC clock, async active-low reset
//  channel_enable           bit i enables sequencer index i
//  command_*                Avalon-ST command to the ADC IP
//  response_*               Avalon-ST response from the ADC IP
//  out_data/out_channel     averaged sample and its ADC channel number
//  out_stb/out_ack          output strobe held until acknowledged
//  overflow/overflow_clr    sticky dropped-result flag and its clear
module adc_sequencer
  import adc_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned CHANNEL_BASE = 1,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned AVG_LOG2     = 4,
  parameter int unsigned SIGNED_OUT   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CHANNELS-1:0] channel_enable,
  output logic                    command_valid,
  output logic [ADC_CH_W-1:0]     command_channel,
  output logic                    command_startofpacket,
  output logic                    command_endofpacket,
  input  logic                    command_ready,
  input  logic                    response_valid,
  input  logic [ADC_CH_W-1:0]     response_channel,
  input  logic [DATA_W-1:0]       response_data,
  output logic [DATA_W-1:0]       out_data,
  output logic [ADC_CH_W-1:0]     out_channel,
  output logic                    out_stb,
  input  logic                    out_ack,
  output logic                    overflow,
  input  logic                    overflow_clr
);

  localparam int unsigned IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic                  armed_q, armed_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      lowest_c, highest_c, next_c;
  logic                  lowest_found_c, next_found_c;
  logic                  cur_en_c, cmd_fire_c;

  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic [ADC_CH_W-1:0]   out_channel_q, out_channel_d;
  logic                  out_stb_q, out_stb_d;
  logic                  overflow_q, overflow_d;

  logic [IDX_CALC_W-1:0] resp_idx_c;
  logic                  resp_in_range_c;
  logic [NUM_CHANNELS-1:0] sample_valid_c;
  logic [NUM_CHANNELS-1:0] done_c;
  logic [DATA_W-1:0]     result_c [NUM_CHANNELS];

  logic                  res_valid_c;
  logic [DATA_W-1:0]     res_data_c;
  logic [ADC_CH_W-1:0]   res_channel_c;

  // Lowest/highest enabled index and next enabled index above the current one.
  always_comb begin
    lowest_c       = '0;
    highest_c      = '0;
    next_c         = '0;
    lowest_found_c = 1'b0;
    next_found_c   = 1'b0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (channel_enable[i]) begin
        if (!lowest_found_c) begin
          lowest_c       = IDX_W'(i);
          lowest_found_c = 1'b1;
        end
        highest_c = IDX_W'(i);
        if (!next_found_c && (IDX_W'(i) > idx_q)) begin
          next_c       = IDX_W'(i);
          next_found_c = 1'b1;
        end
      end
    end
    if (!next_found_c) next_c = lowest_c;
  end

  // Command side. armed_q keeps all command outputs low through reset.
  always_comb begin
    cur_en_c              = channel_enable[idx_q];
    command_valid         = armed_q & cur_en_c;
    command_channel       = armed_q ? (ADC_CH_W'(CHANNEL_BASE) + ADC_CH_W'(idx_q)) : '0;
    command_startofpacket = command_valid & (idx_q == lowest_c);
    command_endofpacket   = command_valid & (idx_q == highest_c);
    cmd_fire_c            = command_valid & command_ready;
    armed_d               = 1'b1;
    idx_d                 = idx_q;
    // A disabled current index jumps to the lowest enabled one without issuing.
    if (!cur_en_c)       idx_d = lowest_c;
    else if (cmd_fire_c) idx_d = next_c;
  end

  // Response decode into per-channel sample strobes.
  always_comb begin
    resp_idx_c      = ch_to_idx(response_channel, CHANNEL_BASE);
    resp_in_range_c = resp_idx_c < IDX_CALC_W'(NUM_CHANNELS);
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    assign sample_valid_c[g] = response_valid & resp_in_range_c &
                               (resp_idx_c == IDX_CALC_W'(g));

    adc_channel_avg #(
      .DATA_W     (DATA_W),
      .AVG_LOG2   (AVG_LOG2),
      .SIGNED_OUT (SIGNED_OUT)
    ) u_avg (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (channel_enable[g]),
      .sample_valid (sample_valid_c[g]),
      .sample_data  (response_data),
      .done_c       (done_c[g]),
      .result_c     (result_c[g])
    );
  end

  // At most one channel completes per cycle (one response per cycle).
  always_comb begin
    res_valid_c   = 1'b0;
    res_data_c    = '0;
    res_channel_c = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (done_c[i]) begin
        res_valid_c   = 1'b1;
        res_data_c    = result_c[i];
        res_channel_c = ADC_CH_W'(CHANNEL_BASE) + ADC_CH_W'(i);
      end
    end
  end

  // Output register with drop-on-busy and sticky overflow (set beats clear).
  always_comb begin
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_stb_d     = out_stb_q;
    overflow_d    = overflow_q;
    if (out_stb_q && out_ack) out_stb_d = 1'b0;
    if (overflow_clr)         overflow_d = 1'b0;
    if (res_valid_c) begin
      if (!out_stb_q || out_ack) begin
        out_data_d    = res_data_c;
        out_channel_d = res_channel_c;
        out_stb_d     = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q       <= 1'b0;
      idx_q         <= '0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_stb_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      armed_q       <= armed_d;
      idx_q         <= idx_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_stb_q     <= out_stb_d;
      overflow_q    <= overflow_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;
  assign out_stb     = out_stb_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Self-checking bench for adc_sequencer: a 4-sample averaging signed instance
// (scoreboarded outputs) and a pass-through unsigned instance.
module tb_adc_sequencer;

  logic        clk;
  logic        rst_n;

  // Main instance: AVG_LOG2=2, SIGNED_OUT=1
  logic [1:0]  channel_enable;
  logic        command_valid, command_startofpacket, command_endofpacket;
  logic [4:0]  command_channel;
  logic        command_ready;
  logic        response_valid;
  logic [4:0]  response_channel;
  logic [11:0] response_data;
  logic [11:0] out_data;
  logic [4:0]  out_channel;
  logic        out_stb, out_ack, overflow, overflow_clr;

  // Pass-through instance: AVG_LOG2=0, SIGNED_OUT=0
  logic [1:0]  en0;
  logic        c0_valid, c0_sop, c0_eop;
  logic [4:0]  c0_channel;
  logic        rdy0;
  logic        resp0_valid;
  logic [4:0]  resp0_channel;
  logic [11:0] resp0_data;
  logic [11:0] out0_data;
  logic [4:0]  out0_channel;
  logic        out0_stb, ack0, ovf0, clr0;

  int vectors;
  int miscompares;

  logic [16:0] exp_q[$];
  int          m_acc [2];
  int          m_cnt [2];

  adc_sequencer #(
    .NUM_CHANNELS(2), .CHANNEL_BASE(1), .DATA_W(12), .AVG_LOG2(2), .SIGNED_OUT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .channel_enable(channel_enable),
    .command_valid(command_valid), .command_channel(command_channel),
    .command_startofpacket(command_startofpacket), .command_endofpacket(command_endofpacket),
    .command_ready(command_ready), .response_valid(response_valid),
    .response_channel(response_channel), .response_data(response_data),
    .out_data(out_data), .out_channel(out_channel), .out_stb(out_stb), .out_ack(out_ack),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  adc_sequencer #(
    .NUM_CHANNELS(2), .CHANNEL_BASE(1), .DATA_W(12), .AVG_LOG2(0), .SIGNED_OUT(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .channel_enable(en0),
    .command_valid(c0_valid), .command_channel(c0_channel),
    .command_startofpacket(c0_sop), .command_endofpacket(c0_eop),
    .command_ready(rdy0), .response_valid(resp0_valid),
    .response_channel(resp0_channel), .response_data(resp0_data),
    .out_data(out0_data), .out_channel(out0_channel), .out_stb(out0_stb), .out_ack(ack0),
    .overflow(ovf0), .overflow_clr(clr0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Scoreboard: every accepted output of the main instance is compared in order.
  always @(negedge clk) begin
    if (rst_n && out_stb && out_ack) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_unexpected: got ch=%0d data=%h, required no output",
                 out_channel, out_data);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({out_channel, out_data} !== e) begin
          miscompares++;
          $display("FAIL scoreboard: got ch=%0d data=%h, required ch=%0d data=%h",
                   out_channel, out_data, e[16:12], e[11:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic [1:0] v);
    channel_enable = v;
    for (int i = 0; i < 2; i++) begin
      if (!v[i]) begin
        m_acc[i] = 0;
        m_cnt[i] = 0;
      end
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0;
      m_cnt[i] = 0;
    end
  endtask

  // One response to the main instance; models the average and queues the
  // expected result when push is set (push=0 marks a result that must be dropped).
  task automatic send(input int ch, input logic [11:0] d, input bit push);
    int idx;
    logic [11:0] e;
    response_valid   = 1'b1;
    response_channel = 5'(ch);
    response_data    = d;
    idx = ch - 1;
    if (idx >= 0 && idx < 2 && channel_enable[idx]) begin
      m_acc[idx] += int'(d);
      m_cnt[idx]++;
      if (m_cnt[idx] == 4) begin
        e = 12'(m_acc[idx] >>> 2) ^ 12'h800;
        if (push) exp_q.push_back({5'(ch), e});
        m_acc[idx] = 0;
        m_cnt[idx] = 0;
      end
    end
    tick();
    response_valid = 1'b0;
  endtask

  task automatic send0(input int ch, input logic [11:0] d);
    resp0_valid   = 1'b1;
    resp0_channel = 5'(ch);
    resp0_data    = d;
    tick();
    resp0_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    clear_model();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if ({command_valid, command_channel, command_startofpacket, command_endofpacket} !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_cmd: got v=%b ch=%0d sop=%b eop=%b, required all 0",
               command_valid, command_channel, command_startofpacket, command_endofpacket);
    end
    vectors++;
    if ({out_stb, out_data, out_channel, overflow} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_out: got stb=%b data=%h ch=%0d ovf=%b, required all 0",
               out_stb, out_data, out_channel, overflow);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (command_valid !== 1'b1 || command_channel !== 5'd1 || command_startofpacket !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_cmd: got v=%b ch=%0d sop=%b, required v=1 ch=1 sop=1",
               command_valid, command_channel, command_startofpacket);
    end
  endtask

  task automatic test_round_robin();
    int exp_ch;
    exp_ch = 1;
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (command_valid !== 1'b1 || command_channel !== 5'(exp_ch) ||
          command_startofpacket !== (exp_ch == 1) || command_endofpacket !== (exp_ch == 2)) begin
        miscompares++;
        $display("FAIL rr_cmd[%0d]: got v=%b ch=%0d sop=%b eop=%b, required v=1 ch=%0d sop=%b eop=%b",
                 k, command_valid, command_channel, command_startofpacket, command_endofpacket,
                 exp_ch, exp_ch == 1, exp_ch == 2);
      end
      tick();
      exp_ch = 3 - exp_ch;
    end
    send(1, 12'h800, 1'b1);
    send(1, 12'h802, 1'b1);
    send(1, 12'h804, 1'b1);
    send(1, 12'h806, 1'b1);
    vectors++;
    if (out_stb !== 1'b1 || out_data !== 12'h003 || out_channel !== 5'd1) begin
      miscompares++;
      $display("FAIL avg_ch1: got stb=%b data=%h ch=%0d, required stb=1 data=003 ch=1",
               out_stb, out_data, out_channel);
    end
    tick();
  endtask

  task automatic test_single_enable();
    set_en(2'b01);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (command_valid !== 1'b1 || command_channel !== 5'd1 ||
          command_startofpacket !== 1'b1 || command_endofpacket !== 1'b1) begin
        miscompares++;
        $display("FAIL single_cmd[%0d]: got v=%b ch=%0d sop=%b eop=%b, required v=1 ch=1 sop=1 eop=1",
                 k, command_valid, command_channel, command_startofpacket, command_endofpacket);
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      send(2, 12'h555, 1'b1);
      vectors++;
      if (out_stb !== 1'b0) begin
        miscompares++;
        $display("FAIL disabled_ch2[%0d]: got stb=%b, required stb=0", k, out_stb);
      end
    end
    for (int k = 0; k < 4; k++) send(1, 12'h200, 1'b1);
    tick();
    set_en(2'b11);
    tick();
  endtask

  task automatic test_overflow();
    out_ack = 1'b0;
    for (int k = 0; k < 4; k++) send(1, 12'h400, 1'b1);
    for (int k = 0; k < 4; k++) send(2, 12'h010, 1'b0);
    vectors++;
    if (out_stb !== 1'b1 || out_data !== 12'hC00 || out_channel !== 5'd1 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_hold: got stb=%b data=%h ch=%0d ovf=%b, required stb=1 data=c00 ch=1 ovf=1",
               out_stb, out_data, out_channel, overflow);
    end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clr: got ovf=%b, required 0", overflow);
    end
    // Drop and clear in the same cycle: set wins.
    for (int k = 0; k < 3; k++) send(2, 12'h020, 1'b0);
    overflow_clr = 1'b1;
    send(2, 12'h020, 1'b0);
    overflow_clr = 1'b0;
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set_wins: got ovf=%b, required 1", overflow);
    end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    // Ack and new result in the same cycle: new result loads.
    for (int k = 0; k < 3; k++) send(1, 12'h000, 1'b1);
    out_ack = 1'b1;
    send(1, 12'h000, 1'b1);
    vectors++;
    if (out_stb !== 1'b1 || out_data !== 12'h800 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_and_load: got stb=%b data=%h ovf=%b, required stb=1 data=800 ovf=0",
               out_stb, out_data, overflow);
    end
    tick();
  endtask

  task automatic test_passthrough();
    send0(1, 12'hABC);
    vectors++;
    if (out0_stb !== 1'b1 || out0_data !== 12'hABC || out0_channel !== 5'd1) begin
      miscompares++;
      $display("FAIL pass_abc: got stb=%b data=%h ch=%0d, required stb=1 data=abc ch=1",
               out0_stb, out0_data, out0_channel);
    end
    send0(9, 12'h111);
    vectors++;
    if (out0_stb !== 1'b0) begin
      miscompares++;
      $display("FAIL pass_ch9: got stb=%b, required stb=0", out0_stb);
    end
    send0(0, 12'h222);
    vectors++;
    if (out0_stb !== 1'b0) begin
      miscompares++;
      $display("FAIL pass_ch0: got stb=%b, required stb=0", out0_stb);
    end
    send0(2, 12'h123);
    vectors++;
    if (out0_stb !== 1'b1 || out0_data !== 12'h123 || out0_channel !== 5'd2) begin
      miscompares++;
      $display("FAIL pass_ch2: got stb=%b data=%h ch=%0d, required stb=1 data=123 ch=2",
               out0_stb, out0_data, out0_channel);
    end
    tick();
  endtask

  task automatic test_reset_mid_average();
    send(1, 12'h100, 1'b1);
    send(1, 12'h100, 1'b1);
    pulse_reset();
    vectors++;
    if (out_stb !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_out: got stb=%b ovf=%b, required 0 0", out_stb, overflow);
    end
    for (int k = 0; k < 4; k++) send(1, 12'hFFF, 1'b1);
    vectors++;
    if (out_stb !== 1'b1 || out_data !== 12'h7FF || out_channel !== 5'd1) begin
      miscompares++;
      $display("FAIL midreset_avg: got stb=%b data=%h ch=%0d, required stb=1 data=7ff ch=1",
               out_stb, out_data, out_channel);
    end
    tick();
  endtask

  task automatic test_back_to_back_ready();
    int  exp_ch;
    bit  r;
    pulse_reset();
    exp_ch = 1;
    for (int k = 0; k < 40; k++) begin
      vectors++;
      if (command_valid !== 1'b1 || command_channel !== 5'(exp_ch)) begin
        miscompares++;
        $display("FAIL rand_ready[%0d]: got v=%b ch=%0d, required v=1 ch=%0d",
                 k, command_valid, command_channel, exp_ch);
      end
      r = bit'($urandom_range(1, 0));
      command_ready = r;
      tick();
      if (r) exp_ch = 3 - exp_ch;
    end
    command_ready = 1'b1;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    command_ready  = 1'b1;
    response_valid = 1'b0;
    response_channel = '0;
    response_data  = '0;
    out_ack        = 1'b1;
    overflow_clr   = 1'b0;
    en0            = 2'b11;
    rdy0           = 1'b1;
    resp0_valid    = 1'b0;
    resp0_channel  = '0;
    resp0_data     = '0;
    ack0           = 1'b1;
    clr0           = 1'b0;
    clear_model();
    set_en(2'b11);

    test_reset();
    test_round_robin();
    test_single_enable();
    test_overflow();
    test_passthrough();
    test_reset_mid_average();
    test_back_to_back_ready();

    tick();
    tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d results never produced, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
